display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_pkg.sv | 28 ++
 rtl/scan_prescaler.sv | 31 +++
 rtl/display_scan_ctrl.sv | 110 +++++++++++
 tb/tb_display_scan_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, constants and blanking helper for the scan display
package display_pkg;

   localparam int NUM_DIGITS = 4;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

   typedef enum logic {
      S_DEAD  = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

   // Slot k > 0 goes dark when it and every nibble above it are zero; slot 0 always shows.
   function automatic logic [NUM_DIGITS-1:0] blank_mask(
      input logic [4*NUM_DIGITS-1:0] val,
      input logic                    en
   );
      logic [NUM_DIGITS-1:0] m;
      logic                  upper_zero;
      m          = '0;
      upper_zero = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         upper_zero = upper_zero && (val[4*k +: 4] == 4'd0);
         m[k]       = en && upper_zero;
      end
      return m;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - per-slot cycle counter and digit slot counter with wrap strobe
module scan_prescaler
   import display_pkg::*;
#(
   parameter int PRESCALE = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   output logic [$clog2(PRESCALE)-1:0]   cnt,
   output logic [$clog2(NUM_DIGITS)-1:0] slot,
   output logic                          wrap
);

   localparam int CW = $clog2(PRESCALE);
   localparam int SW = $clog2(NUM_DIGITS);

   assign wrap = (cnt == CW'(PRESCALE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         slot <= '0;
      end else if (wrap) begin
         cnt  <= '0;
         slot <= slot + SW'(1);
      end else begin
         cnt  <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - four-digit multiplexed display scanner with double-buffered value
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int PRESCALE = 8,
   parameter int DEAD     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] value,
   input  logic        blank_lz,
   output logic        ready,
   output logic [1:0]  refrescamiento,
   output logic [3:0]  digito,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int     CW          = $clog2(PRESCALE);
   localparam int     SW          = $clog2(NUM_DIGITS);
   localparam state_t RESET_STATE = (DEAD == 0) ? S_DRIVE : S_DEAD;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [SW-1:0] slot;
   logic [SW-1:0] slot_nxt;
   logic          wrap;
   logic          boundary;

   state_t        state;
   state_t        state_nxt;

   logic [15:0]   active;
   logic [15:0]   shadow;
   logic [15:0]   active_nxt;
   logic          pending;

   logic [NUM_DIGITS-1:0] blank_nxt;
   logic [3:0]            an_nxt;
   logic [3:0]            digit_nxt;

   scan_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .cnt  (cnt),
      .slot (slot),
      .wrap (wrap)
   );

   // Outputs are registered, so everything below is evaluated for the coming cycle.
   assign cnt_nxt    = wrap ? '0 : cnt + CW'(1);
   assign slot_nxt   = wrap ? slot + SW'(1) : slot;
   assign boundary   = wrap && (slot == SW'(NUM_DIGITS - 1));
   assign active_nxt = (boundary && pending) ? shadow : active;

   assign frame_tick     = boundary;
   assign ready          = !pending;
   assign refrescamiento = slot;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RESET_STATE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_DEAD:  if (cnt_nxt >= CW'(DEAD)) state_nxt = S_DRIVE;
         S_DRIVE: if (wrap && (DEAD != 0)) state_nxt = S_DEAD;
         default: state_nxt = RESET_STATE;
      endcase
   end

   always_comb begin
      blank_nxt = blank_mask(active_nxt, blank_lz);
      digit_nxt = active_nxt[4*slot_nxt +: 4];
      an_nxt    = AN_OFF;
      if ((state_nxt == S_DRIVE) && !blank_nxt[slot_nxt]) begin
         an_nxt = ~(4'b0001 << slot_nxt);
      end
   end

   // The shadow is only freed at a frame boundary, so a capture there waits a full frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         active  <= '0;
         shadow  <= '0;
         pending <= 1'b0;
         digito  <= '0;
         an      <= AN_OFF;
      end else begin
         active <= active_nxt;
         if (boundary && pending) begin
            pending <= 1'b0;
         end else if (load && !pending) begin
            shadow  <= value;
            pending <= 1'b1;
         end
         digito <= digit_nxt;
         an     <= an_nxt;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - randomized scoreboard bench for display_scan_ctrl
module tb_display_scan_ctrl;

   localparam int P     = 8;
   localparam int D     = 2;
   localparam int FRAME = 4 * P;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] value;
   logic        blank_lz;
   logic        ready;
   logic [1:0]  refrescamiento;
   logic [3:0]  digito;
   logic [3:0]  an;
   logic        frame_tick;

   always #5 clk = ~clk;

   display_scan_ctrl #(
      .PRESCALE (P),
      .DEAD     (D)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .load           (load),
      .value          (value),
      .blank_lz       (blank_lz),
      .ready          (ready),
      .refrescamiento (refrescamiento),
      .digito         (digito),
      .an             (an),
      .frame_tick     (frame_tick)
   );

   typedef struct packed {
      logic [1:0] refr;
      logic [3:0] dig;
      logic [3:0] an;
      logic       rdy;
      logic       tick;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: n counts cycles since reset; values move on frame-boundary arithmetic.
   bit          model_valid = 0;
   int          n           = 0;
   logic [15:0] disp        = '0;
   logic [15:0] pend_val    = '0;
   bit          pend        = 0;
   int          pend_until  = 0;
   bit          blank_prev  = 0;

   function automatic bit is_blank(input int k, input logic [15:0] v, input bit en);
      if (!en || k == 0) return 1'b0;
      for (int j = k; j < 4; j++) begin
         if (((v >> (4 * j)) & 16'hF) != 16'h0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      int   s;
      int   c;
      s      = (n / P) % 4;
      c      = n % P;
      e.refr = 2'(s);
      e.dig  = 4'((disp >> (4 * s)) & 16'hF);
      e.rdy  = !pend;
      e.tick = (s == 3) && (c == P - 1);
      if (n == 0 || c < D || is_blank(s, disp, blank_prev)) e.an = 4'hF;
      else e.an = ~(4'b0001 << s);
      return e;
   endfunction

   task automatic step(input bit r, input bit ld, input logic [15:0] v, input bit bl);
      @(negedge clk);
      if (model_valid) exp_q.push_back(model_out());
      rst      = r;
      load     = ld;
      value    = v;
      blank_lz = bl;
      if (r) begin
         model_valid = 1;
         n           = 0;
         disp        = '0;
         pend        = 0;
         pend_val    = '0;
         blank_prev  = bl;
      end else if (model_valid) begin
         if (ld && !pend) begin
            pend     = 1;
            pend_val = v;
            if (n % FRAME == FRAME - 1) pend_until = n + FRAME;
            else pend_until = n + (FRAME - 1 - n % FRAME);
         end else if (pend && n == pend_until) begin
            disp = pend_val;
            pend = 0;
         end
         blank_prev = bl;
         n++;
      end
   endtask

   task automatic goto_phase(input int phase, input bit bl);
      int guard;
      guard = 0;
      while ((n % FRAME) != phase && guard < 2 * FRAME) begin
         step(0, 0, 16'h0, bl);
         guard++;
      end
   endtask

   function automatic logic [15:0] rand_value();
      logic [15:0] v;
      for (int k = 0; k < 4; k++) begin
         v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("refrescamiento", 16'(refrescamiento), 16'(e.refr));
            chk("digito",         16'(digito),         16'(e.dig));
            chk("an",             16'(an),             16'(e.an));
            chk("ready",          16'(ready),          16'(e.rdy));
            chk("frame_tick",     16'(frame_tick),     16'(e.tick));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      bit          r;
      bit          ld;
      bit          bl;
      logic [15:0] v;

      rst      = 1'b1;
      load     = 1'b0;
      value    = '0;
      blank_lz = 1'b0;

      step(1, 0, 16'h0, 0);
      step(1, 0, 16'h0, 0);
      repeat (64) step(0, 0, 16'h0, 0);

      // Capture mid-slot 1, shown from the next frame.
      goto_phase(P + 3, 0);
      step(0, 1, 16'h1234, 0);
      repeat (2 * FRAME) step(0, 0, 16'h0, 0);

      // Leading-zero blanking.
      goto_phase(5, 1);
      step(0, 1, 16'h0050, 1);
      repeat (2 * FRAME) step(0, 0, 16'h0, 1);

      // Loads while the shadow is busy are dropped.
      goto_phase(5, 0);
      step(0, 1, 16'h0777, 0);
      repeat (5) step(0, 1, 16'hAAAA, 0);
      repeat (2 * FRAME) step(0, 0, 16'h0, 0);

      // Capture on the boundary cycle itself.
      goto_phase(FRAME - 1, 0);
      step(0, 1, 16'h9999, 0);
      repeat (2 * FRAME + 4) step(0, 0, 16'h0, 0);

      // Reset mid-slot 2 discards the pending value.
      goto_phase(P + 2, 0);
      step(0, 1, 16'h4321, 0);
      goto_phase(2 * P + 3, 0);
      step(1, 0, 16'h0, 0);
      repeat (2 * FRAME) step(0, 0, 16'h0, 0);

      bl = 0;
      for (int i = 0; i < 1500; i++) begin
         r  = ($urandom_range(0, 499) == 0);
         ld = ($urandom_range(0, 7) == 0);
         v  = rand_value();
         if ($urandom_range(0, 63) == 0) bl = !bl;
         step(r, ld, v, bl);
      end

      step(0, 0, 16'h0, 0);
      @(negedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
